// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receive and transmit paths.
//   rx_state_e          : receive FSM states
//   PRESC_8/16/32       : legal oversampling ratios (ticks per bit)
//   PAR_EVEN / PAR_ODD  : encodings of the PAR_TYP input
// ----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_core_if.sv
// ----------------------------------------------------------------------------
// uart_rx_core_if
// Bundles the serial line, the frame configuration and the parallel result of
// the UART receiver.
//   master : drives RX_IN, PRESCALE, PAR_EN and PAR_TYP; observes the results
//   slave  : the receiver; consumes the line/config and drives P_DATA,
//            data_valid, parity_error and stop_error
// ----------------------------------------------------------------------------
interface uart_rx_core_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
);

  logic                  RX_IN;
  logic [PRESC_W-1:0]    PRESCALE;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  parity_error;
  logic                  stop_error;

  modport master (
    output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
    input  P_DATA, data_valid, parity_error, stop_error
  );

  modport slave (
    input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
    output P_DATA, data_valid, parity_error, stop_error
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// ----------------------------------------------------------------------------
// uart_rx_sampler
// Per-bit edge counter and 3-sample majority voter of the UART receiver.
//   CLK, RST     : oversampling clock, asynchronous active-low reset
//   rx_in        : serial line (already synchronized)
//   run          : receiver is inside a frame (FSM not in IDLE)
//   prescale     : ticks per bit for the current frame
//   sampled_bit  : majority of the samples at ticks P/2-1, P/2, P/2+1
//   bit_tick     : high during tick P-1 of each bit
//   sample_done  : one-cycle pulse during tick P/2+2, when sampled_bit is new
// ----------------------------------------------------------------------------
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               rx_in,
  input  logic               run,
  input  logic [PRESC_W-1:0] prescale,
  output logic               sampled_bit,
  output logic               bit_tick,
  output logic               sample_done
);

  logic [PRESC_W-1:0] edge_cnt;
  logic [PRESC_W-1:0] mid;
  logic [PRESC_W-1:0] last_tick;
  logic [1:0]         samples;
  logic               enable;

  // The low level seen in IDLE is tick 0 of the start bit, so counting is
  // enabled in that cycle too, not only once the FSM has left IDLE.
  assign enable    = run | ~rx_in;
  assign mid       = prescale >> 1;
  assign last_tick = prescale - PRESC_W'(1);
  assign bit_tick  = enable && (edge_cnt == last_tick);

  // Edge counter: 0..P-1 per bit, parked at 0 while the line idles. A
  // wrap-around of the counter itself still yields a bit_tick for any
  // prescale value, so the FSM can never stall.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
    end else if (!enable) begin
      edge_cnt <= '0;
    end else if (edge_cnt == last_tick) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + PRESC_W'(1);
    end
  end

  // Voter: the first two samples are stored, the third is taken live on the
  // edge that ends tick P/2+1, so the voted bit is valid from tick P/2+2.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      samples     <= '0;
      sampled_bit <= 1'b1;
      sample_done <= 1'b0;
    end else begin
      sample_done <= 1'b0;
      if (enable) begin
        if (edge_cnt == mid - PRESC_W'(1)) begin
          samples[0] <= rx_in;
        end
        if (edge_cnt == mid) begin
          samples[1] <= rx_in;
        end
        if (edge_cnt == mid + PRESC_W'(1)) begin
          sampled_bit <= (samples[0] & samples[1]) |
                         (samples[0] & rx_in) |
                         (samples[1] & rx_in);
          sample_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// ----------------------------------------------------------------------------
// uart_rx_core
// UART receive path: start detection with glitch rejection, majority-voted
// bits, LSB-first deserialization, optional parity and stop-bit checking.
//   CLK  : oversampling clock (PRESCALE ticks per bit)
//   RST  : asynchronous active-low reset
//   bus  : uart_rx_core_if.slave
//          in : RX_IN, PRESCALE (8/16/32), PAR_EN, PAR_TYP (0 even, 1 odd)
//          out: P_DATA (last good byte), data_valid / parity_error /
//               stop_error (one-cycle pulses at the end of a frame)
// ----------------------------------------------------------------------------
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input logic          CLK,
  input logic          RST,
  uart_rx_core_if.slave bus
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  rx_state_e             state;
  logic [PRESC_W-1:0]    presc_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [BCW-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_err;
  logic                  stp_err;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  data_valid_q;
  logic                  parity_error_q;
  logic                  stop_error_q;

  logic                  run;
  logic [PRESC_W-1:0]    presc_eff;
  logic                  sampled_bit;
  logic                  bit_tick;
  logic                  sample_done;

  // During the start-detect cycle the latched prescale is not loaded yet, so
  // the sampler sees the live input for that single cycle.
  assign run       = (state != IDLE);
  assign presc_eff = run ? presc_q : bus.PRESCALE;

  uart_rx_sampler #(
    .PRESC_W (PRESC_W)
  ) u_sampler (
    .CLK         (CLK),
    .RST         (RST),
    .rx_in       (bus.RX_IN),
    .run         (run),
    .prescale    (presc_eff),
    .sampled_bit (sampled_bit),
    .bit_tick    (bit_tick),
    .sample_done (sample_done)
  );

  // Receive FSM with registered result outputs. Error flags accumulate
  // during the frame and are only turned into pulses on the final tick of
  // the stop bit, so the FSM is back in IDLE in the cycle the pulse shows.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= IDLE;
      presc_q        <= '0;
      par_en_q       <= 1'b0;
      par_typ_q      <= 1'b0;
      bit_cnt        <= '0;
      shift_reg      <= '0;
      par_err        <= 1'b0;
      stp_err        <= 1'b0;
      p_data_q       <= '0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
    end else begin
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.RX_IN) begin
            state     <= START;
            presc_q   <= bus.PRESCALE;
            par_en_q  <= bus.PAR_EN;
            par_typ_q <= bus.PAR_TYP;
            bit_cnt   <= '0;
            par_err   <= 1'b0;
            stp_err   <= 1'b0;
          end
        end
        START: begin
          if (bit_tick) begin
            state <= sampled_bit ? IDLE : DATA;
          end
        end
        DATA: begin
          if (sample_done) begin
            shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
          end
          if (bit_tick) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end
        end
        PARITY: begin
          if (sample_done && (sampled_bit != ((^shift_reg) ^ par_typ_q))) begin
            par_err <= 1'b1;
          end
          if (bit_tick) begin
            state <= STOP;
          end
        end
        STOP: begin
          if (sample_done && !sampled_bit) begin
            stp_err <= 1'b1;
          end
          if (bit_tick) begin
            state <= IDLE;
            if (!par_err && !stp_err) begin
              p_data_q     <= shift_reg;
              data_valid_q <= 1'b1;
            end else begin
              parity_error_q <= par_err;
              stop_error_q   <= stp_err;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.P_DATA       = p_data_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.parity_error = parity_error_q;
  assign bus.stop_error   = stop_error_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_core
// Self-checking bench for uart_rx_core. Frames are serialized bit by bit from
// their byte value; each frame's expected outcome (cycle, pulses, byte) is
// queued when it is sent and a monitor checks every result pulse against it.
// ----------------------------------------------------------------------------
module tb_uart_rx_core;
  import uart_pkg::*;

  typedef struct {
    int         due;
    bit         dv;
    bit         pe;
    bit         se;
    logic [7:0] data;
  } exp_t;

  logic       CLK;
  logic       RST;
  int         pcnt = 0;
  int         n_compared = 0;
  int         n_mismatched = 0;
  logic [7:0] model_pdata = 8'h00;
  exp_t       exp_q[$];
  exp_t       mon_e;

  uart_rx_core_if #(.DATA_WIDTH(8), .PRESC_W(6)) bus ();

  uart_rx_core #(
    .DATA_WIDTH (8),
    .PRESC_W    (6)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Clock and a posedge counter used as the timebase for expected latencies
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) pcnt <= pcnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic int pickPrescale();
    int sel;
    sel = $urandom_range(0, 2);
    case (sel)
      0:       return PRESC_8;
      1:       return PRESC_16;
      default: return PRESC_32;
    endcase
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_P_DATA"}, 32'(bus.P_DATA), 32'h0);
    checkOutput({tag, "_data_valid"}, 32'(bus.data_valid), 32'h0);
    checkOutput({tag, "_parity_error"}, 32'(bus.parity_error), 32'h0);
    checkOutput({tag, "_stop_error"}, 32'(bus.stop_error), 32'h0);
  endtask

  task automatic idleLine(input int n);
    bus.RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  // Sends one frame starting at the current negedge. abort_bit >= 0 asserts
  // reset halfway through that bit index (0 = start bit) instead of finishing.
  task automatic applyStimulus(input logic [7:0] data, input int p,
                               input bit par_en, input bit par_typ,
                               input bit flip_par, input bit stop_bit,
                               input int abort_bit);
    bit   bits[$];
    exp_t e;
    int   n;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (par_en) bits.push_back((^data) ^ par_typ ^ flip_par);
    bits.push_back(stop_bit);
    n = bits.size();
    bus.PRESCALE = 6'(p);
    bus.PAR_EN   = par_en;
    bus.PAR_TYP  = par_typ;
    if (abort_bit < 0) begin
      e.due  = pcnt + n * p;
      e.pe   = par_en && flip_par;
      e.se   = !stop_bit;
      e.dv   = !(e.pe || e.se);
      e.data = data;
      exp_q.push_back(e);
    end
    for (int b = 0; b < n; b++) begin
      bus.RX_IN = bits[b];
      if (b == abort_bit) begin
        repeat (p / 2) @(negedge CLK);
        RST = 1'b0;
        repeat (3) begin
          @(negedge CLK);
          checkAllZero("reset_midframe");
        end
        bus.RX_IN = 1'b1;
        model_pdata = 8'h00;
        RST = 1'b1;
        @(negedge CLK);
        return;
      end
      if (b == 0) begin
        // Config changes after the start bit must not affect this frame
        @(negedge CLK);
        bus.PRESCALE = 6'(pickPrescale());
        bus.PAR_EN   = ($urandom_range(0, 1) == 1);
        bus.PAR_TYP  = ($urandom_range(0, 1) == 1);
        repeat (p - 1) @(negedge CLK);
      end else begin
        repeat (p) @(negedge CLK);
      end
    end
  endtask

  // Monitor: every result pulse must match the oldest outstanding frame
  always @(negedge CLK) begin
    if (RST && (bus.data_valid || bus.parity_error || bus.stop_error)) begin
      checkOutput("expected_pending", 32'(exp_q.size() != 0), 32'h1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        checkOutput("event_cycle", 32'(pcnt), 32'(mon_e.due));
        checkOutput("data_valid", 32'(bus.data_valid), 32'(mon_e.dv));
        checkOutput("parity_error", 32'(bus.parity_error), 32'(mon_e.pe));
        checkOutput("stop_error", 32'(bus.stop_error), 32'(mon_e.se));
        if (mon_e.dv) model_pdata = mon_e.data;
        checkOutput("P_DATA", 32'(bus.P_DATA), 32'(model_pdata));
      end
    end
  end

  initial begin
    logic [7:0] rdata;
    int         rp;
    bit         ren, rtyp, rflip, rstop;
    int         waited;

    RST          = 1'b0;
    bus.RX_IN    = 1'b1;
    bus.PRESCALE = 6'(PRESC_8);
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = PAR_EVEN;
    repeat (3) @(negedge CLK);
    checkAllZero("reset");
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    $display("[TB] directed frames");
    applyStimulus(8'hA5, PRESC_8, 1'b1, PAR_EVEN, 1'b0, 1'b1, -1);
    idleLine(3);

    // Two-tick start glitch: must be rejected silently
    bus.PRESCALE = 6'(PRESC_16);
    bus.RX_IN    = 1'b0;
    repeat (2) @(negedge CLK);
    idleLine(40);
    checkOutput("glitch_pdata_hold", 32'(bus.P_DATA), 32'(model_pdata));

    applyStimulus(8'h3C, PRESC_8, 1'b1, PAR_ODD, 1'b1, 1'b1, -1);
    idleLine(3);
    applyStimulus(8'h55, PRESC_32, 1'b0, PAR_EVEN, 1'b0, 1'b0, -1);
    idleLine(3);
    applyStimulus(8'h55, PRESC_32, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1);
    applyStimulus(8'hAA, PRESC_32, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1);
    idleLine(3);
    applyStimulus(8'hF0, PRESC_16, 1'b0, PAR_EVEN, 1'b0, 1'b1, 4);
    applyStimulus(8'h0F, PRESC_16, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1);
    idleLine(3);

    $display("[TB] random frames");
    for (int k = 0; k < 24; k++) begin
      rdata = 8'($urandom_range(0, 255));
      rp    = pickPrescale();
      ren   = ($urandom_range(0, 1) == 1);
      rtyp  = ($urandom_range(0, 1) == 1);
      rflip = ($urandom_range(0, 4) == 0);
      rstop = ($urandom_range(0, 5) != 0);
      applyStimulus(rdata, rp, ren, rtyp, rflip, rstop, -1);
      idleLine($urandom_range(0, 3));
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 1000) begin
      @(negedge CLK);
      waited++;
    end
    checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);
    idleLine(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
